// File: rtl/sram_burst_port.sv
// Single-port SRAM with an auto-incrementing address pointer for byte-stream transfers.
// An optional post-reset sweep zero-fills the array before any request is accepted.
module sram_burst_port #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ADDR_W        = 10,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ptr_load_i,
    input  logic [ADDR_W-1:0] ptr_value_i,
    input  logic              req_valid_i,
    input  logic              req_write_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              req_ready_o,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              init_busy_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {StInit, StRun} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = req_wdata_i;
        req_ready_o = 1'b0;
        unique case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (&cnt_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    if (req_write_i) begin
                        mem_we = 1'b1;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = mem_q[ptr_q];
                    end
                end
                // Load overrides the increment; the request above already used the old pointer.
                if (ptr_load_i) begin
                    ptr_d = ptr_value_i;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT_ON_RESET ? StInit : StRun;
            cnt_q       <= '0;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Array is not reset; writes are suppressed while reset is held.
    always_ff @(posedge clock) begin
        if (mem_we && reset_n) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign ptr_o       = ptr_q;
    assign init_busy_o = (state_q == StInit);

endmodule

// File: tb/tb_sram_burst_port.sv
// Bench for sram_burst_port: directed steps plus randomized traffic checked against a
// pointer/array reference model; small-depth instances cover the sweep and no-sweep cases.
module tb_sram_burst_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default geometry, sweep enabled.
    logic       a_rst_n = 1'b0;
    logic       a_ptr_load = 1'b0;
    logic [9:0] a_ptr_value = '0;
    logic       a_valid = 1'b0;
    logic       a_write = 1'b0;
    logic [7:0] a_wdata = '0;
    logic       a_ready, a_rsp_valid, a_busy;
    logic [7:0] a_rsp_data;
    logic [9:0] a_ptr;

    // Small instances share inputs: s sweeps, n does not.
    logic       s_rst_n = 1'b0;
    logic       s_ptr_load = 1'b0;
    logic [3:0] s_ptr_value = '0;
    logic       s_valid = 1'b0;
    logic       s_write = 1'b0;
    logic [7:0] s_wdata = '0;
    logic       s_ready, s_rsp_valid, s_busy, n_ready, n_rsp_valid, n_busy;
    logic [7:0] s_rsp_data, n_rsp_data;
    logic [3:0] s_ptr, n_ptr;

    sram_burst_port #(.DATA_W(8), .ADDR_W(10), .INIT_ON_RESET(1'b1)) u_a (
        .clock(clk), .reset_n(a_rst_n), .ptr_load_i(a_ptr_load), .ptr_value_i(a_ptr_value),
        .req_valid_i(a_valid), .req_write_i(a_write), .req_wdata_i(a_wdata),
        .req_ready_o(a_ready), .rsp_valid_o(a_rsp_valid), .rsp_data_o(a_rsp_data),
        .ptr_o(a_ptr), .init_busy_o(a_busy)
    );

    sram_burst_port #(.DATA_W(8), .ADDR_W(4), .INIT_ON_RESET(1'b1)) u_s (
        .clock(clk), .reset_n(s_rst_n), .ptr_load_i(s_ptr_load), .ptr_value_i(s_ptr_value),
        .req_valid_i(s_valid), .req_write_i(s_write), .req_wdata_i(s_wdata),
        .req_ready_o(s_ready), .rsp_valid_o(s_rsp_valid), .rsp_data_o(s_rsp_data),
        .ptr_o(s_ptr), .init_busy_o(s_busy)
    );

    sram_burst_port #(.DATA_W(8), .ADDR_W(4), .INIT_ON_RESET(1'b0)) u_n (
        .clock(clk), .reset_n(s_rst_n), .ptr_load_i(s_ptr_load), .ptr_value_i(s_ptr_value),
        .req_valid_i(s_valid), .req_write_i(s_write), .req_wdata_i(s_wdata),
        .req_ready_o(n_ready), .rsp_valid_o(n_rsp_valid), .rsp_data_o(n_rsp_data),
        .ptr_o(n_ptr), .init_busy_o(n_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model of the main instance.
    logic [7:0] m_mem [1024];
    int         m_ptr;
    logic       m_vld;
    logic [7:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_mem[i] = 8'h00;
        m_ptr  = 0;
        m_vld  = 1'b0;
        m_data = 8'h00;
    endtask

    // One clock of main-instance traffic, then compare against the model.
    task automatic cycle(input string tag, input bit ld, input logic [9:0] val, input bit vld,
                         input bit wr, input logic [7:0] wd);
        a_ptr_load  = ld;
        a_ptr_value = val;
        a_valid     = vld;
        a_write     = wr;
        a_wdata     = wd;
        @(posedge clk);
        m_vld = 1'b0;
        if (vld) begin
            if (wr) begin
                m_mem[m_ptr] = wd;
            end else begin
                m_vld  = 1'b1;
                m_data = m_mem[m_ptr];
            end
            m_ptr = (m_ptr + 1) % 1024;
        end
        if (ld) m_ptr = val;
        #1;
        check({tag, "_ptr"}, 32'(a_ptr), 32'(m_ptr));
        check({tag, "_rsp_valid"}, 32'(a_rsp_valid), 32'(m_vld));
        check({tag, "_rsp_data"}, 32'(a_rsp_data), 32'(m_data));
    endtask

    task automatic count_sweep(output int n);
        n = 0;
        for (int i = 0; i < 1100 && a_busy; i++) begin
            if (a_ready) n = n + 10000;
            n++;
            step();
        end
    endtask

    initial begin
        int n_cnt;
        bit s_ready_bad;
        bit n_busy_seen;
        model_reset();

        step();
        step();
        check("rst_ptr", 32'(a_ptr), 0);
        check("rst_rsp_valid", 32'(a_rsp_valid), 0);
        check("rst_rsp_data", 32'(a_rsp_data), 0);
        check("rst_busy", 32'(a_busy), 1);
        check("rst_ready", 32'(a_ready), 0);

        a_rst_n = 1'b1;
        s_rst_n = 1'b1;

        // Small sweep length and the no-sweep variant.
        check("n_ready_first", 32'(n_ready), 1);
        n_cnt = 0;
        s_ready_bad = 1'b0;
        n_busy_seen = 1'b0;
        for (int i = 0; i < 40 && s_busy; i++) begin
            n_cnt++;
            if (s_ready) s_ready_bad = 1'b1;
            if (n_busy) n_busy_seen = 1'b1;
            step();
        end
        check("s_busy_cycles", 32'(n_cnt), 16);
        check("s_ready_in_sweep", 32'(s_ready_bad), 0);
        check("n_busy_seen", 32'(n_busy_seen), 0);
        check("s_ready_after", 32'(s_ready), 1);

        s_ptr_load  = 1'b1;
        s_ptr_value = 4'd5;
        step();
        s_ptr_load = 1'b0;
        s_valid    = 1'b1;
        s_write    = 1'b0;
        step();
        s_valid = 1'b0;
        check("s_read_ptr", 32'(s_ptr), 6);
        check("s_read_valid", 32'(s_rsp_valid), 1);
        check("s_read_data", 32'(s_rsp_data), 0);
        check("n_read_valid", 32'(n_rsp_valid), 1);
        step();
        check("s_read_valid_drop", 32'(s_rsp_valid), 0);

        // Main instance: finish the sweep.
        for (int i = 0; i < 1100 && a_busy; i++) step();
        check("a_sweep_done", 32'(a_busy), 0);
        check("a_ready_run", 32'(a_ready), 1);

        // Writes across the wrap, then read them back.
        cycle("wrap_load", 1'b1, 10'h3FE, 1'b0, 1'b0, 8'h00);
        cycle("wrap_w0", 1'b0, 10'h000, 1'b1, 1'b1, 8'hA1);
        check("wrap_w0_ptr_k", 32'(a_ptr), 32'h3FF);
        cycle("wrap_w1", 1'b0, 10'h000, 1'b1, 1'b1, 8'hB2);
        check("wrap_w1_ptr_k", 32'(a_ptr), 32'h000);
        cycle("wrap_w2", 1'b0, 10'h000, 1'b1, 1'b1, 8'hC3);
        check("wrap_w2_ptr_k", 32'(a_ptr), 32'h001);
        cycle("wrap_reload", 1'b1, 10'h3FE, 1'b0, 1'b0, 8'h00);
        cycle("wrap_r0", 1'b0, 10'h000, 1'b1, 1'b0, 8'h00);
        check("wrap_r0_k", 32'(a_rsp_data), 32'hA1);
        cycle("wrap_r1", 1'b0, 10'h000, 1'b1, 1'b0, 8'h00);
        check("wrap_r1_k", 32'(a_rsp_data), 32'hB2);
        cycle("wrap_r2", 1'b0, 10'h000, 1'b1, 1'b0, 8'h00);
        check("wrap_r2_k", 32'(a_rsp_data), 32'hC3);
        cycle("wrap_idle", 1'b0, 10'h000, 1'b0, 1'b1, 8'h00);

        // Load collides with an accepted write.
        cycle("coll_load", 1'b1, 10'h007, 1'b0, 1'b0, 8'h00);
        cycle("coll_wr", 1'b1, 10'h020, 1'b1, 1'b1, 8'h55);
        check("coll_ptr_k", 32'(a_ptr), 32'h020);
        cycle("coll_reload", 1'b1, 10'h007, 1'b0, 1'b0, 8'h00);
        cycle("coll_rd", 1'b0, 10'h000, 1'b1, 1'b0, 8'h00);
        check("coll_rd_k", 32'(a_rsp_data), 32'h55);

        // Read-after-write via reload; write must not pulse rsp_valid.
        cycle("raw_load", 1'b1, 10'h009, 1'b0, 1'b0, 8'h00);
        cycle("raw_wr", 1'b0, 10'h000, 1'b1, 1'b1, 8'h3C);
        check("raw_wr_novalid_k", 32'(a_rsp_valid), 0);
        cycle("raw_reload", 1'b1, 10'h009, 1'b0, 1'b0, 8'h00);
        cycle("raw_rd", 1'b0, 10'h000, 1'b1, 1'b0, 8'h00);
        check("raw_rd_k", 32'(a_rsp_data), 32'h3C);

        // Randomized traffic in a small window so reads hit written data.
        for (int i = 0; i < 300; i++) begin
            cycle("rand", ($urandom_range(0, 7) == 0), 10'(10'h100 + $urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
        end

        // Reset mid-burst.
        cycle("mid_load", 1'b1, 10'h010, 1'b0, 1'b0, 8'h00);
        cycle("mid_w10", 1'b0, 10'h000, 1'b1, 1'b1, 8'h66);
        cycle("mid_w11", 1'b0, 10'h000, 1'b1, 1'b1, 8'h77);
        check("mid_ptr_k", 32'(a_ptr), 32'h012);
        cycle("mid_rd", 1'b0, 10'h000, 1'b1, 1'b0, 8'h00);
        a_valid = 1'b0;
        a_rst_n = 1'b0;
        #1;
        check("mid_rst_ptr", 32'(a_ptr), 0);
        check("mid_rst_valid", 32'(a_rsp_valid), 0);
        check("mid_rst_busy", 32'(a_busy), 1);
        model_reset();
        step();
        a_rst_n = 1'b1;
        count_sweep(n_cnt);
        check("a_sweep_cycles", 32'(n_cnt), 1024);
        cycle("post_load", 1'b1, 10'h011, 1'b0, 1'b0, 8'h00);
        cycle("post_rd", 1'b0, 10'h000, 1'b1, 1'b0, 8'h00);
        check("post_rd_k", 32'(a_rsp_data), 32'h00);
        check("post_rd_valid_k", 32'(a_rsp_valid), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_burst_port.md
Name: sram_burst_port

Overview:
Parametrised single-port SRAM with an internal auto-incrementing address pointer. It sits behind the I2C slave front end and serves byte-stream transfers. The pointer is loaded once per transfer, then successive read and write requests walk memory sequentially. After reset, an optional sweep clears the whole array to zero before any request is accepted.

Parameters:
DATA_W, 8, width of one memory word in bits.
ADDR_W, 10, pointer width; memory depth is DEPTH = 2**ADDR_W words.
INIT_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = skip the sweep (contents undefined at power-up).

Ports:
clock  input  1  system clock; all logic is posedge.
reset_n  input  1  asynchronous, active-low reset.
ptr_load  input  1  when high, load the pointer from ptr_value.
ptr_value  input  ADDR_W  new pointer value.
req_valid  input  1  a request is presented.
req_write  input  1  1 = write request, 0 = read request; sampled with req_valid.
req_wdata  input  DATA_W  write data.
req_ready  output  1  block can accept a request this cycle.
rsp_valid  output  1  read data valid; single-cycle pulse.
rsp_data  output  DATA_W  read data.
ptr  output  ADDR_W  current pointer.
init_busy  output  1  zero-fill sweep in progress.

Behaviour:
- Reset is asynchronous and takes effect immediately.
  - Outputs: ptr=0, rsp_valid=0, rsp_data=0.
  - State: INIT if INIT_ON_RESET=1, else RUN.
  - Array contents are not changed by reset itself.
- States: INIT and RUN.
- INIT:
  - sweep counter starts at 0; each cycle write 0 to mem[counter], then counter+1.
  - After writing address DEPTH-1, go to RUN.
  - init_busy=1 for exactly DEPTH cycles after reset release; req_ready=0 throughout.
  - ptr_load is ignored.
- RUN:
  - req_ready=1 every cycle; no backpressure.
  - A request is accepted when req_valid && req_ready.
- Accepted write: mem[ptr] <= req_wdata at that edge.
- Accepted read:
  - rsp_data <= mem[ptr]; rsp_valid=1 in the following cycle only (latency 1).
  - rsp_data holds its value until the next read response.
- Pointer update:
  - Every accepted request increments ptr by 1, modulo DEPTH (DEPTH-1 wraps to 0).
- Same-cycle ptr_load and accepted request:
  - The request uses the old ptr.
  - Then ptr <= ptr_value; the load wins over the increment.
- ptr_load with no request: ptr <= ptr_value next cycle.
- Read-after-write:
  - A write at edge N is visible to a read accepted at edge N+1 or later.
  - Reading freshly written data therefore requires reloading ptr first.
- Reset during INIT restarts the sweep from address 0.
- Reset during RUN drops any pending rsp_valid (forced to 0).
- req_write is ignored when req_valid=0.
- rsp_valid never asserts for writes.

Test Plan:
1. Release reset with INIT_ON_RESET=1, ADDR_W=4 -> init_busy high exactly 16 cycles; req_ready low during the sweep. Then load ptr=5 and read -> rsp_data=0x00.
2. In RUN: load ptr=0x3FE, then write 0xA1, 0xB2, 0xC3 back-to-back -> ptr goes 0x3FF, 0x000, 0x001. Reload ptr=0x3FE, then 3 reads -> rsp_data 0xA1, 0xB2, 0xC3 on consecutive cycles, each one cycle after acceptance.
3. Present a write of 0x55 at ptr=7 together with ptr_load, ptr_value=0x20 -> mem[7]=0x55 and ptr=0x20 (not 8).
4. Write 0x3C at ptr=9, reload ptr=9, read -> rsp_data=0x3C. Check that rsp_valid never pulses for the write.
5. Assert reset_n low mid-burst (ptr=0x12, a read just accepted) -> ptr=0 and rsp_valid=0 immediately. The sweep restarts; after it completes, mem[0x11]=0x00.
6. Set INIT_ON_RESET=0 -> req_ready=1 in the first cycle after reset release; init_busy is never asserted.
